// File: rtl/rv64g_l2_dir_array.sv
// L2 directory array: per-way valid/sharers/owner/dirty with sweep-based init.
// Optional per-way even parity: define RV64G_L2_DIR_PARITY_EN.
module rv64g_l2_dir_array #(
    parameter int SETS  = 256,
    parameter int WAYS  = 16,
    parameter int CORES = 4,
    localparam int OW = (CORES > 1) ? $clog2(CORES) : 1,
    localparam int SW = $clog2(SETS),
    localparam int WW = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  inv_all_i,
    output logic                  init_done_o,
    input  logic                  rd_req_valid_i,
    output logic                  rd_req_ready_o,
    input  logic [SW-1:0]         rd_set_i,
    output logic                  rd_rsp_valid_o,
    output logic [WAYS-1:0]       rd_valid_o,
    output logic [WAYS*CORES-1:0] rd_sharers_o,
    output logic [WAYS-1:0]       rd_owner_valid_o,
    output logic [WAYS*OW-1:0]    rd_owner_id_o,
    output logic [WAYS-1:0]       rd_dirty_o,
    output logic [WAYS-1:0]       rd_parity_err_o,
    input  logic                  wr_valid_i,
    output logic                  wr_ready_o,
    input  logic [SW-1:0]         wr_set_i,
    input  logic [WW-1:0]         wr_way_i,
    input  logic                  wr_entry_valid_i,
    input  logic [CORES-1:0]      wr_sharers_i,
    input  logic                  wr_owner_valid_i,
    input  logic [OW-1:0]         wr_owner_id_i,
    input  logic                  wr_dirty_i
);

    // Entry layout: {valid, sharers, owner_valid, owner_id, dirty} (+ parity on top)
    localparam int DW = CORES + OW + 3;
`ifdef RV64G_L2_DIR_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int EW = DW + PB;
    localparam int RW = WAYS * EW;

    typedef enum logic {SWEEP, READY} state_t;

    state_t            state;
    logic [SW-1:0]     cnt;
    logic [SW-1:0]     sweep_idx;
    logic [RW-1:0]     mem [SETS];
    logic [RW-1:0]     rrow;
    logic [RW-1:0]     rd_q;
    logic [EW-1:0]     wdata;
    logic              w_ov;
    logic [CORES-1:0]  w_sh;
    logic              rd_fire;
    logic              wr_fire;
    logic              ready;

    assign ready          = (state == READY) && !inv_all_i;
    assign rd_req_ready_o = ready;
    assign wr_ready_o     = ready;
    assign init_done_o    = (state == READY);
    assign rd_fire        = rd_req_valid_i && ready;
    assign wr_fire        = wr_valid_i && ready
                            && ({1'b0, wr_way_i} < (WW+1)'(WAYS));
    assign sweep_idx      = inv_all_i ? '0 : cnt;

    // Sanitise write data: dirty implies owner, owner clears sharers, invalid zeroes all
    always_comb begin
        w_ov  = wr_owner_valid_i | wr_dirty_i;
        w_sh  = w_ov ? '0 : wr_sharers_i;
        wdata = '0;
        if (wr_entry_valid_i) begin
            wdata[DW-1:0] = {1'b1, w_sh, w_ov, wr_owner_id_i, wr_dirty_i};
        end
`ifdef RV64G_L2_DIR_PARITY_EN
        wdata[EW-1] = ^wdata[DW-1:0];
`endif
    end

    // Read row with write-first forwarding of a same-cycle write to the same set
    always_comb begin
        rrow = mem[rd_set_i];
        if (wr_fire && (wr_set_i == rd_set_i)) begin
            rrow[int'(wr_way_i)*EW +: EW] = wdata;
        end
    end

    // Storage: cleared one set per cycle by the sweep, otherwise updated by writes
    always_ff @(posedge clk) begin
        if (state == SWEEP) begin
            mem[sweep_idx] <= '0;
        end else if (wr_fire) begin
            mem[wr_set_i][int'(wr_way_i)*EW +: EW] <= wdata;
        end
    end

    // Sweep/ready state machine; inv_all restarts the sweep from set 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SWEEP;
            cnt   <= '0;
        end else begin
            unique case (state)
                SWEEP: begin
                    if (inv_all_i) begin
                        cnt <= SW'(1);
                    end else if (cnt == SW'(SETS-1)) begin
                        state <= READY;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + SW'(1);
                    end
                end
                READY: begin
                    if (inv_all_i) begin
                        state <= SWEEP;
                        cnt   <= '0;
                    end
                end
                default: begin
                    state <= SWEEP;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Registered read response, held until the next accepted read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_rsp_valid_o <= 1'b0;
            rd_q           <= '0;
        end else begin
            rd_rsp_valid_o <= rd_fire;
            if (rd_fire) begin
                rd_q <= rrow;
            end
        end
    end

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        assign rd_dirty_o[w]               = rd_q[w*EW];
        assign rd_owner_id_o[w*OW +: OW]   = rd_q[w*EW+1 +: OW];
        assign rd_owner_valid_o[w]         = rd_q[w*EW+OW+1];
        assign rd_sharers_o[w*CORES +: CORES] = rd_q[w*EW+OW+2 +: CORES];
        assign rd_valid_o[w]               = rd_q[w*EW+DW-1];
`ifdef RV64G_L2_DIR_PARITY_EN
        assign rd_parity_err_o[w]          = ^rd_q[w*EW +: EW];
`else
        assign rd_parity_err_o[w]          = 1'b0;
`endif
    end

endmodule

// File: tb/tb_rv64g_l2_dir_array.sv
// Directed bench for rv64g_l2_dir_array (SETS=256, WAYS=16, CORES=4).
// Parity fault step is built only with RV64G_L2_DIR_PARITY_EN.
module tb_rv64g_l2_dir_array;

    localparam int SETS = 256;
    localparam int WAYS = 16;
    localparam int CORES = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        inv_all_i;
    logic        init_done_o;
    logic        rd_req_valid_i;
    logic        rd_req_ready_o;
    logic [7:0]  rd_set_i;
    logic        rd_rsp_valid_o;
    logic [15:0] rd_valid_o;
    logic [63:0] rd_sharers_o;
    logic [15:0] rd_owner_valid_o;
    logic [31:0] rd_owner_id_o;
    logic [15:0] rd_dirty_o;
    logic [15:0] rd_parity_err_o;
    logic        wr_valid_i;
    logic        wr_ready_o;
    logic [7:0]  wr_set_i;
    logic [3:0]  wr_way_i;
    logic        wr_entry_valid_i;
    logic [3:0]  wr_sharers_i;
    logic        wr_owner_valid_i;
    logic [1:0]  wr_owner_id_i;
    logic        wr_dirty_i;

    int checks = 0;
    int failures = 0;

    rv64g_l2_dir_array #(.SETS(SETS), .WAYS(WAYS), .CORES(CORES)) dut (
        .clk(clk), .rst_n(rst_n), .inv_all_i(inv_all_i),
        .init_done_o(init_done_o),
        .rd_req_valid_i(rd_req_valid_i), .rd_req_ready_o(rd_req_ready_o),
        .rd_set_i(rd_set_i), .rd_rsp_valid_o(rd_rsp_valid_o),
        .rd_valid_o(rd_valid_o), .rd_sharers_o(rd_sharers_o),
        .rd_owner_valid_o(rd_owner_valid_o), .rd_owner_id_o(rd_owner_id_o),
        .rd_dirty_o(rd_dirty_o), .rd_parity_err_o(rd_parity_err_o),
        .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o),
        .wr_set_i(wr_set_i), .wr_way_i(wr_way_i),
        .wr_entry_valid_i(wr_entry_valid_i), .wr_sharers_i(wr_sharers_i),
        .wr_owner_valid_i(wr_owner_valid_i), .wr_owner_id_i(wr_owner_id_i),
        .wr_dirty_i(wr_dirty_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [7:0] s, input logic [3:0] w,
                            input logic v, input logic [3:0] sh,
                            input logic ov, input logic [1:0] id,
                            input logic d);
        wr_valid_i = 1'b1;
        wr_set_i = s;
        wr_way_i = w;
        wr_entry_valid_i = v;
        wr_sharers_i = sh;
        wr_owner_valid_i = ov;
        wr_owner_id_i = id;
        wr_dirty_i = d;
        @(negedge clk);
        wr_valid_i = 1'b0;
    endtask

    task automatic do_read(input logic [7:0] s);
        rd_req_valid_i = 1'b1;
        rd_set_i = s;
        @(negedge clk);
        rd_req_valid_i = 1'b0;
        chk("rsp_valid", 64'(rd_rsp_valid_o), 64'd1);
    endtask

    // Counts negedges (one per rising edge) until init_done, bounded
    task automatic wait_init(input string tag, input int start,
                             input int exp);
        int n = start;
        while (!init_done_o && n < 600) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 64'(n), 64'(exp));
    endtask

    // Back-to-back reads of every set; all responses valid, all masks zero
    task automatic sweep_check(input string tag);
        int miss = 0;
        logic [15:0] acc = '0;
        rd_req_valid_i = 1'b1;
        rd_set_i = 8'd0;
        for (int s = 1; s <= SETS; s++) begin
            @(negedge clk);
            if (rd_rsp_valid_o !== 1'b1) miss++;
            acc |= rd_valid_o;
            if (s < SETS) rd_set_i = 8'(s);
            else rd_req_valid_i = 1'b0;
        end
        chk({tag, "_rsp_miss"}, 64'(miss), 64'd0);
        chk({tag, "_valid_or"}, 64'(acc), 64'd0);
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        inv_all_i = 1'b0;
        rd_req_valid_i = 1'b0;
        rd_set_i = '0;
        wr_valid_i = 1'b0;
        wr_set_i = '0;
        wr_way_i = '0;
        wr_entry_valid_i = 1'b0;
        wr_sharers_i = '0;
        wr_owner_valid_i = 1'b0;
        wr_owner_id_i = '0;
        wr_dirty_i = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_init_done", 64'(init_done_o), 64'd0);
        chk("rst_rsp_valid", 64'(rd_rsp_valid_o), 64'd0);
        chk("rst_rd_valid", 64'(rd_valid_o), 64'd0);
        chk("rst_rd_sharers", rd_sharers_o, 64'd0);
        chk("rst_rd_ready", 64'(rd_req_ready_o), 64'd0);

        rst_n = 1'b1;
        wait_init("init_cycles", 0, 256);
        chk("ready_up", 64'({rd_req_ready_o, wr_ready_o}), 64'd3);
        sweep_check("init");
        @(negedge clk);
        chk("rsp_pulse_drop", 64'(rd_rsp_valid_o), 64'd0);

        do_write(8'd5, 4'd3, 1'b1, 4'b0110, 1'b0, 2'd0, 1'b0);
        do_read(8'd5);
        chk("s5_sharers_w3", 64'(rd_sharers_o[15:12]), 64'h6);
        chk("s5_valid", 64'(rd_valid_o), 64'h0008);
        chk("s5_owner_valid", 64'(rd_owner_valid_o), 64'h0);

        do_write(8'd9, 4'd0, 1'b1, 4'b1111, 1'b0, 2'd2, 1'b1);
        do_read(8'd9);
        chk("s9_owner_valid", 64'(rd_owner_valid_o), 64'h0001);
        chk("s9_sharers", rd_sharers_o, 64'h0);
        chk("s9_dirty", 64'(rd_dirty_o), 64'h0001);
        chk("s9_owner_id", 64'(rd_owner_id_o[1:0]), 64'd2);
        chk("s9_valid", 64'(rd_valid_o), 64'h0001);

        rd_req_valid_i = 1'b1;
        rd_set_i = 8'd7;
        wr_valid_i = 1'b1;
        wr_set_i = 8'd7;
        wr_way_i = 4'd15;
        wr_entry_valid_i = 1'b1;
        wr_sharers_i = 4'b0001;
        wr_owner_valid_i = 1'b0;
        wr_owner_id_i = 2'd0;
        wr_dirty_i = 1'b0;
        @(negedge clk);
        rd_req_valid_i = 1'b0;
        wr_valid_i = 1'b0;
        chk("fwd_rsp_valid", 64'(rd_rsp_valid_o), 64'd1);
        chk("fwd_valid", 64'(rd_valid_o), 64'h8000);
        chk("fwd_sharers", 64'(rd_sharers_o[63:60]), 64'h1);
        do_read(8'd7);
        chk("s7_stored", 64'(rd_valid_o), 64'h8000);

        do_write(8'd5, 4'd3, 1'b0, 4'b1111, 1'b1, 2'd3, 1'b1);
        do_read(8'd5);
        chk("s5_invalid_valid", 64'(rd_valid_o), 64'h0);
        chk("s5_invalid_sharers", rd_sharers_o, 64'h0);
        chk("s5_invalid_dirty", 64'(rd_dirty_o), 64'h0);

        rd_req_valid_i = 1'b1;
        rd_set_i = 8'd9;
        @(negedge clk);
        rd_req_valid_i = 1'b0;
        inv_all_i = 1'b1;
        #1;
        chk("inv_rd_ready", 64'(rd_req_ready_o), 64'd0);
        chk("inv_wr_ready", 64'(wr_ready_o), 64'd0);
        chk("pre_inv_rsp", 64'(rd_rsp_valid_o), 64'd1);
        chk("pre_inv_dirty", 64'(rd_dirty_o), 64'h0001);
        @(negedge clk);
        inv_all_i = 1'b0;
        chk("inv_init_drop", 64'(init_done_o), 64'd0);
        chk("inv_no_rsp", 64'(rd_rsp_valid_o), 64'd0);
        wait_init("inv_cycles", 0, 256);
        sweep_check("inv");

        inv_all_i = 1'b1;
        @(negedge clk);
        inv_all_i = 1'b0;
        n = 0;
        while (!init_done_o && n < 600) begin
            @(negedge clk);
            n++;
            if (n == 100) inv_all_i = 1'b1;
            if (n == 101) inv_all_i = 1'b0;
        end
        chk("restart_cycles", 64'(n), 64'd356);

        rd_req_valid_i = 1'b1;
        rd_set_i = 8'd7;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        rd_req_valid_i = 1'b0;
        #1;
        chk("rst_mid_rsp", 64'(rd_rsp_valid_o), 64'd0);
        chk("rst_mid_init", 64'(init_done_o), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_release_rsp", 64'(rd_rsp_valid_o), 64'd0);
        wait_init("reinit_cycles", 1, 256);
        do_read(8'd7);
        chk("reinit_s7_zero", 64'(rd_valid_o), 64'h0);
        chk("no_parity_err", 64'(rd_parity_err_o), 64'h0);

`ifdef RV64G_L2_DIR_PARITY_EN
        dut.mem[1][20] = ~dut.mem[1][20];
        do_read(8'd1);
        chk("parity_err", 64'(rd_parity_err_o), 64'h0004);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
